// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM arbiter: FSM state encoding and
// read-latency legalisation and counter sizing.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 4;

  function automatic bit latency_in_range(input int lat);
    return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
  endfunction

  // Out-of-range latencies are clamped to the nearest supported value.
  function automatic int legal_latency(input int lat);
    if (latency_in_range(lat)) begin
      return lat;
    end else if (lat < MIN_READ_LATENCY) begin
      return MIN_READ_LATENCY;
    end else begin
      return MAX_READ_LATENCY;
    end
  endfunction

  // Wait counter holds 0..lat-1.
  function automatic int wait_cnt_width(input int lat);
    if (lat <= 2) begin
      return 1;
    end else begin
      return $clog2(lat);
    end
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requesting index scanning upward
// from last_grant+1, wrapping modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  logic found_s;
  logic hit_s;

  // Priority scan from the slot after the previous winner.
  always_comb begin
    grant   = {N{1'b0}};
    index   = {IW{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      hit_s = !found_s && req[IW'((int'(last_grant) + k) % N)];
      grant[IW'((int'(last_grant) + k) % N)] = grant[IW'((int'(last_grant) + k) % N)] | hit_s;
      index   = hit_s ? IW'((int'(last_grant) + k) % N) : index;
      found_s = found_s | hit_s;
    end
    any = found_s;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank pair between
// REQUESTERS ports; one access in flight, all outputs registered.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int REQUESTERS        = 4,
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 16,
  parameter int READ_LATENCY      = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [REQUESTERS-1:0]                  req_valid,
  input  logic [REQUESTERS-1:0]                  req_write,
  input  logic [REQUESTERS*ADDRESS_BUS_WIDTH-1:0] req_addr,
  input  logic [REQUESTERS*DATA_BUS_WIDTH-1:0]   req_wdata,
  output logic [REQUESTERS-1:0]                  req_ready,
  output logic [REQUESTERS-1:0]                  rsp_valid,
  output logic [DATA_BUS_WIDTH-1:0]              rsp_data,
  output logic [ADDRESS_BUS_WIDTH-1:0]           mem_addr,
  output logic [DATA_BUS_WIDTH-1:0]              mem_wdata,
  output logic                                   mem_wren,
  input  logic [DATA_BUS_WIDTH-1:0]              mem_rdata,
  output logic                                   busy
);

  localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int LAT   = legal_latency(READ_LATENCY);
  localparam int CNT_W = wait_cnt_width(LAT);

  state_t                  state_r;
  logic [IDX_W-1:0]        last_grant_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    write_r;
  logic [CNT_W-1:0]        wait_cnt_r;

  logic [REQUESTERS-1:0]   pick_grant_s;
  logic [IDX_W-1:0]        pick_idx_s;
  logic                    pick_any_s;
  logic [REQUESTERS-1:0]   rsp_onehot_s;

  logic [ADDRESS_BUS_WIDTH-1:0] addr_s  [REQUESTERS];
  logic [DATA_BUS_WIDTH-1:0]    wdata_s [REQUESTERS];

  for (genvar g = 0; g < REQUESTERS; g++) begin : g_unpack
    assign addr_s[g]  = req_addr[g*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
    assign wdata_s[g] = req_wdata[g*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
  end

  assign rsp_onehot_s = {{(REQUESTERS-1){1'b0}}, 1'b1} << idx_r;

  rr_picker #(
    .N  (REQUESTERS),
    .IW (IDX_W)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (pick_grant_s),
    .index      (pick_idx_s),
    .any        (pick_any_s)
  );

  // Arbiter FSM; the winner's address/data are latched straight into the memory port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= IDX_W'(REQUESTERS - 1);
      idx_r        <= {IDX_W{1'b0}};
      write_r      <= 1'b0;
      wait_cnt_r   <= {CNT_W{1'b0}};
      req_ready    <= {REQUESTERS{1'b0}};
      rsp_valid    <= {REQUESTERS{1'b0}};
      rsp_data     <= {DATA_BUS_WIDTH{1'b0}};
      mem_addr     <= {ADDRESS_BUS_WIDTH{1'b0}};
      mem_wdata    <= {DATA_BUS_WIDTH{1'b0}};
      mem_wren     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      req_ready <= {REQUESTERS{1'b0}};
      rsp_valid <= {REQUESTERS{1'b0}};
      mem_wren  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            req_ready    <= pick_grant_s;
            last_grant_r <= pick_idx_s;
            idx_r        <= pick_idx_s;
            write_r      <= req_write[pick_idx_s];
            mem_addr     <= addr_s[pick_idx_s];
            mem_wdata    <= wdata_s[pick_idx_s];
            mem_wren     <= req_write[pick_idx_s];
            state_r      <= ST_ISSUE;
            busy         <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (write_r) begin
            rsp_valid <= rsp_onehot_s;
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
          end else begin
            wait_cnt_r <= CNT_W'(LAT - 1);
            state_r    <= ST_WAIT;
            busy       <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == {CNT_W{1'b0}}) begin
            rsp_data  <= mem_rdata;
            rsp_valid <= rsp_onehot_s;
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
          end else begin
            wait_cnt_r <= wait_cnt_r - CNT_W'(1'b1);
            busy       <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
